// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-access sequencer: FSM encoding,
// timeout read-fill constant and the default timeout depth.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Value returned to the control unit when a read is abandoned
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

  // Default number of unacknowledged BUSY cycles before abandoning an access
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_bus_if.sv
// Memory-access sequencer between the control unit and the external bus.
// Converts level-held read/write requests into a single valid/ack bus
// transaction and issues a one-cycle ready pulse when it completes.
// Optional feature macro: MEM_BUS_IF_TIMEOUT_EN (abandon stalled accesses
// after TIMEOUT BUSY cycles and raise the sticky oErr flag).
module mem_bus_if
  import mem_bus_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          iClk,
  input  logic          nRst,
  input  logic          iRead,
  input  logic          iWrite,
  input  logic [AW-1:0] iAddr,
  input  logic [DW-1:0] iWData,
  output logic          oRdy,
  output logic [DW-1:0] oRData,
  output logic [AW-1:0] oBusAddr,
  output logic [DW-1:0] oBusWData,
  output logic          oBusRE,
  output logic          oBusWE,
  input  logic          iBusAck,
  input  logic [DW-1:0] iBusRData,
  output logic          oErr
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_bus_if: TIMEOUT must be at least 1");
  end

  state_t state, state_next;
  logic   lat_read, lat_write;
  logic   req;
  logic   expire;

  assign req = iRead | iWrite;

`ifdef MEM_BUS_IF_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // Expiry fires on the TIMEOUT-th unacknowledged BUSY cycle; an ack wins
  assign expire = (state == BUSY) && !iBusAck && (wait_cnt == CW'(TIMEOUT - 1));

  // Count unacknowledged BUSY cycles, restarting for every new access
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      wait_cnt <= '0;
    end else if (state != BUSY) begin
      wait_cnt <= '0;
    end else if (!iBusAck) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      oErr <= 1'b0;
    end else if (expire) begin
      oErr <= 1'b1;
    end
  end
`else
  assign expire = 1'b0;
  assign oErr   = 1'b0;
`endif

  // State register
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, ready and bus strobes; strobes depend only on state so
  // they drop the instant reset is asserted
  always_comb begin
    state_next = state;
    oRdy       = 1'b0;
    oBusRE     = 1'b0;
    oBusWE     = 1'b0;
    case (state)
      IDLE: begin
        oRdy = ~req;
        if (req) state_next = BUSY;
      end
      BUSY: begin
        oBusRE = lat_read;
        oBusWE = lat_write;
        if (iBusAck || expire) state_next = DONE;
      end
      DONE: begin
        oRdy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the request in IDLE (write wins a tie) and capture read data on ack
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      oBusAddr  <= '0;
      oBusWData <= '0;
      oRData    <= '0;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        oBusAddr  <= iAddr;
        oBusWData <= iWData;
        lat_write <= iWrite;
        lat_read  <= iRead & ~iWrite;
      end
      if (state == BUSY && lat_read) begin
        if (iBusAck) begin
          oRData <= iBusRData;
        end else if (expire) begin
          oRData <= DW'(TIMEOUT_FILL);
        end
      end
    end
  end

endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
- Memory-access sequencer between the control unit and the external memory bus.
- Turns the control unit's level-held read/write strobes into one bus transaction with a valid/ack handshake.
- Returns read data to the control unit and the data path, and drives the ready signal that gates step advance.
- Absorbs arbitrary bus wait states so the control unit needs no knowledge of memory timing.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- TIMEOUT, 255, maximum BUSY cycles before an access is abandoned (used only with the optional feature). Must be ≥1.

Ports:
- iClk  in  1  system clock; all state updates on the rising edge.
- nRst  in  1  asynchronous, active-low reset.
- iRead  in  1  read request from the control unit; held until ready is seen.
- iWrite  in  1  write request from the control unit; held until ready is seen.
- iAddr  in  AW  access address.
- iWData  in  DW  store data.
- oRdy  out  1  step-advance permission to the control unit.
- oRData  out  DW  last read data, registered.
- oBusAddr  out  AW  bus address, registered.
- oBusWData  out  DW  bus write data, registered.
- oBusRE  out  1  bus read strobe.
- oBusWE  out  1  bus write strobe.
- iBusAck  in  1  bus completion; read data is valid in the same cycle.
- iBusRData  in  DW  bus read data.
- oErr  out  1  sticky timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values, applied immediately on nRst low: state IDLE; oRData, oBusAddr, oBusWData = 0; oBusRE, oBusWE, oErr = 0; wait counter = 0.
- Reset mid-access: strobes drop at once; the pending transaction is lost; no ready is issued for it.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - oRdy = ~(iRead | iWrite), combinational, so non-memory steps advance freely.
  - On a request, latch iAddr and iWData into oBusAddr and oBusWData, latch direction, and go to BUSY.
  - Both requests asserted together: treated as a write; oRData unchanged.
- BUSY:
  - oRdy = 0.
  - oBusRE = latched read; oBusWE = latched write.
  - On iBusAck: capture iBusRData into oRData if the access is a read, and go to DONE. Strobes are low from DONE onward.
  - Counter increments each BUSY cycle without an ack.
- DONE:
  - oRdy = 1 for exactly one cycle; oRData is stable.
  - Always returns to IDLE next cycle, so the next request is seen fresh.
- Latency:
  - Zero-wait access: request sampled at edge 0, BUSY in cycle 1 with ack, DONE in cycle 2. The control unit advances at the end of cycle 2.
  - Each bus wait state adds one cycle.
- oRData holds its value across writes and idle cycles until the next read ack.
- Request dropped during BUSY: the transaction still completes; DONE/ready is issued harmlessly.
- iBusAck in IDLE or DONE is ignored.
- Addresses pass through unmodified; no alignment checks.

Optional Feature:
- Macro: MEM_BUS_IF_TIMEOUT_EN.
- Defined:
  - If the counter reaches TIMEOUT in BUSY without an ack, go to DONE with oRData = 32'hDEAD_BEEF for reads; writes are dropped.
  - oErr is set and stays set until reset.
  - An ack in the same cycle as expiry wins, and oErr is not set.
- Not defined: BUSY waits indefinitely, the counter logic is absent, and oErr is tied 0.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the FSM state encoding (IDLE, BUSY, DONE);
  - the timeout fill constant 32'hDEAD_BEEF;
  - the default TIMEOUT value.
- Single module; the counter is too small to warrant a sub-module.

Test Plan:
- Zero-wait read:
  - Stimulus: iRead=1, iAddr=0x10, ack in first BUSY cycle with iBusRData=0x12345678.
  - Response: oBusRE high 1 cycle; oRdy high in the 3rd cycle; oRData=0x12345678.
- Wait-state write:
  - Stimulus: iWrite=1, iAddr=0x20, iWData=0xCAFEF00D, ack after 3 wait cycles.
  - Response: oBusWE high 4 cycles; oBusWData=0xCAFEF00D; oRdy pulses once; oRData unchanged.
- Back-to-back reads:
  - Stimulus: request re-asserted the cycle after DONE, addresses 0x0 then 0x4.
  - Response: two distinct bus transactions; oRdy=0 between them; each oRData is correct.
- Reset mid-access:
  - Stimulus: nRst low during BUSY.
  - Response: oBusRE/oBusWE low with no clock edge; after release, oRdy=1 with no request; oRData=0.
- Timeout (macro defined):
  - Stimulus: TIMEOUT=4, read with no ack.
  - Response: DONE after 4 BUSY cycles; oRData=0xDEADBEEF; oErr=1 and stays 1 until reset.
- Spurious/idle ack:
  - Stimulus: iBusAck pulsed with no request active.
  - Response: no state change; oRdy=1; oRData unchanged.
